// File: rtl/dm_cache_ctrl_pkg.sv
// Shared definitions for the direct-mapped cache controller and the cache array:
// the 2-bit cache command encoding, controller state encoding and geometry helpers.
package dm_cache_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_CLR   = 2'b00,
        CMD_CHECK = 2'b01,
        CMD_READ  = 2'b10,
        CMD_WRITE = 2'b11
    } cache_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_CHECK,
        ST_WB,
        ST_FILL,
        ST_ACCESS,
        ST_FILL_WR,
        ST_DONE
    } ctrl_state_e;

    localparam int DEF_RAM_WIDTH       = 8;
    localparam int DEF_ADDR_WIDTH      = 8;
    localparam int DEF_BLOCK_ADDR_BITS = 4;

    function automatic int tag_bits(int addr_width, int block_addr_bits);
        return addr_width - block_addr_bits;
    endfunction

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// Bus bundle around the cache controller: processor request side, cache command
// port and RAM strobe/ack port. master = controller view, slave = environment view.
interface dm_cache_ctrl_if #(
    parameter int RAM_WIDTH  = 8,
    parameter int ADDR_WIDTH = 8
);
    import dm_cache_ctrl_pkg::*;

    logic                  cpu_req;
    logic                  cpu_we;
    logic                  cpu_flush;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [RAM_WIDTH-1:0]  cpu_wdata;
    logic [RAM_WIDTH-1:0]  cpu_rdata;
    logic                  cpu_ready;

    cache_cmd_e            cache_cntrl;
    logic [ADDR_WIDTH-1:0] cache_addr;
    logic [RAM_WIDTH-1:0]  cache_din;
    logic [RAM_WIDTH-1:0]  cache_dout;
    logic                  cache_hit;
    logic                  cache_clean;
    logic [RAM_WIDTH-1:0]  cache_wb_data;
    logic [ADDR_WIDTH-1:0] cache_wb_addr;

    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [RAM_WIDTH-1:0]  ram_wdata;
    logic                  ram_we;
    logic                  ram_re;
    logic [RAM_WIDTH-1:0]  ram_rdata;
    logic                  ram_ack;

    modport master (
        input  cpu_req, cpu_we, cpu_flush, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready,
        output cache_cntrl, cache_addr, cache_din,
        input  cache_dout, cache_hit, cache_clean, cache_wb_data, cache_wb_addr,
        output ram_addr, ram_wdata, ram_we, ram_re,
        input  ram_rdata, ram_ack
    );

    modport slave (
        output cpu_req, cpu_we, cpu_flush, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready,
        input  cache_cntrl, cache_addr, cache_din,
        output cache_dout, cache_hit, cache_clean, cache_wb_data, cache_wb_addr,
        input  ram_addr, ram_wdata, ram_we, ram_re,
        output ram_rdata, ram_ack
    );

endinterface

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped cache controller: sequences CHECK/READ/WRITE/CLR commands to the
// cache array, with dirty write-back and miss fill against RAM. All outputs registered.
module dm_cache_ctrl
    import dm_cache_ctrl_pkg::*;
#(
    parameter int RAM_WIDTH       = DEF_RAM_WIDTH,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int BLOCK_ADDR_BITS = DEF_BLOCK_ADDR_BITS
) (
    input logic              clk,
    input logic              rst_n,
    dm_cache_ctrl_if.master  bus
);

    if (BLOCK_ADDR_BITS < 1 || tag_bits(ADDR_WIDTH, BLOCK_ADDR_BITS) < 1) begin : g_bad_geometry
        $error("dm_cache_ctrl: BLOCK_ADDR_BITS must leave at least one index and one tag bit");
    end

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [RAM_WIDTH-1:0]  wdata;
    } req_t;

    ctrl_state_e           st, st_n;
    cache_cmd_e            cntrl_q, cntrl_n;
    req_t                  req_q, req_n;
    logic                  ready_q, ready_n;
    logic [RAM_WIDTH-1:0]  rdata_q, rdata_n;
    logic [ADDR_WIDTH-1:0] caddr_q, caddr_n;
    logic [RAM_WIDTH-1:0]  din_q, din_n;
    logic [RAM_WIDTH-1:0]  fill_q, fill_n;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_n;
    logic [RAM_WIDTH-1:0]  rwdata_q, rwdata_n;
    logic                  rwe_q, rwe_n;
    logic                  rre_q, rre_n;
    logic                  start_miss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= ST_IDLE;
            cntrl_q  <= CMD_READ;
            req_q    <= '0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            caddr_q  <= '0;
            din_q    <= '0;
            fill_q   <= '0;
            raddr_q  <= '0;
            rwdata_q <= '0;
            rwe_q    <= 1'b0;
            rre_q    <= 1'b0;
        end else begin
            st       <= st_n;
            cntrl_q  <= cntrl_n;
            req_q    <= req_n;
            ready_q  <= ready_n;
            rdata_q  <= rdata_n;
            caddr_q  <= caddr_n;
            din_q    <= din_n;
            fill_q   <= fill_n;
            raddr_q  <= raddr_n;
            rwdata_q <= rwdata_n;
            rwe_q    <= rwe_n;
            rre_q    <= rre_n;
        end
    end

    // READ is the idle command: it has no side effect on the array, unlike CLR.
    always_comb begin
        st_n       = st;
        cntrl_n    = CMD_READ;
        req_n      = req_q;
        ready_n    = 1'b0;
        rdata_n    = rdata_q;
        caddr_n    = caddr_q;
        din_n      = din_q;
        fill_n     = fill_q;
        raddr_n    = raddr_q;
        rwdata_n   = rwdata_q;
        rwe_n      = rwe_q;
        rre_n      = rre_q;
        start_miss = 1'b0;

        unique case (st)
            ST_IDLE: begin
                if (bus.cpu_flush) begin
                    cntrl_n = CMD_CLR;
                    st_n    = ST_FLUSH;
                end else if (bus.cpu_req) begin
                    req_n.we    = bus.cpu_we;
                    req_n.addr  = bus.cpu_addr;
                    req_n.wdata = bus.cpu_wdata;
                    caddr_n     = bus.cpu_addr;
                    cntrl_n     = CMD_CHECK;
                    st_n        = ST_CHECK;
                end
            end
            ST_FLUSH: st_n = ST_IDLE;
            ST_CHECK: begin
                if (bus.cache_hit) begin
                    st_n = ST_ACCESS;
                    if (req_q.we) begin
                        cntrl_n = CMD_WRITE;
                        din_n   = req_q.wdata;
                    end
                end else if (!bus.cache_clean) begin
                    rwe_n    = 1'b1;
                    raddr_n  = bus.cache_wb_addr;
                    rwdata_n = bus.cache_wb_data;
                    st_n     = ST_WB;
                end else begin
                    start_miss = 1'b1;
                end
            end
            ST_WB: begin
                if (bus.ram_ack) begin
                    rwe_n      = 1'b0;
                    start_miss = 1'b1;
                end
            end
            ST_FILL: begin
                if (bus.ram_ack) begin
                    rre_n   = 1'b0;
                    fill_n  = bus.ram_rdata;
                    din_n   = bus.ram_rdata;
                    cntrl_n = CMD_WRITE;
                    st_n    = ST_FILL_WR;
                end
            end
            ST_ACCESS: begin
                ready_n = 1'b1;
                if (!req_q.we) rdata_n = bus.cache_dout;
                st_n = ST_DONE;
            end
            ST_FILL_WR: begin
                ready_n = 1'b1;
                rdata_n = fill_q;
                st_n    = ST_DONE;
            end
            ST_DONE: st_n = ST_IDLE;
            default: st_n = ST_IDLE;
        endcase

        // Line is clean (or just written back): a store overwrites it directly,
        // a load has to fetch the word from RAM first.
        if (start_miss) begin
            if (req_q.we) begin
                cntrl_n = CMD_WRITE;
                din_n   = req_q.wdata;
                st_n    = ST_ACCESS;
            end else begin
                rre_n   = 1'b1;
                raddr_n = req_q.addr;
                st_n    = ST_FILL;
            end
        end
    end

    assign bus.cpu_rdata   = rdata_q;
    assign bus.cpu_ready   = ready_q;
    assign bus.cache_cntrl = cntrl_q;
    assign bus.cache_addr  = caddr_q;
    assign bus.cache_din   = din_q;
    assign bus.ram_addr    = raddr_q;
    assign bus.ram_wdata   = rwdata_q;
    assign bus.ram_we      = rwe_q;
    assign bus.ram_re      = rre_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl: behavioural cache array (acts on negedge) and
// RAM with programmable ack delay; directed requests push expectations, monitors pop.
module tb_dm_cache_ctrl;
    import dm_cache_ctrl_pkg::*;

    localparam int RW = 8;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dm_cache_ctrl_if #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW)) bus ();

    dm_cache_ctrl #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW), .BLOCK_ADDR_BITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_acc = 0;
    int clr_seen = 0;
    int exp_clr = 0;

    typedef struct {
        logic [7:0] rdata;
        int         lat;
        string      name;
    } cpu_exp_t;
    cpu_exp_t cpu_q[$];

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } ram_txn_t;
    ram_txn_t ram_q[$];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // cache array model: powers up all lines valid, tag F, data FF, dirty
    logic [3:0] c_tag[16];
    logic [7:0] c_dat[16];
    logic       c_vld[16];
    logic       c_dty[16];

    initial begin
        for (int i = 0; i < 16; i++) begin
            c_tag[i] = 4'hF; c_dat[i] = 8'hFF; c_vld[i] = 1'b1; c_dty[i] = 1'b1;
        end
        bus.cache_dout = '0; bus.cache_hit = 1'b0; bus.cache_clean = 1'b0;
        bus.cache_wb_data = '0; bus.cache_wb_addr = '0;
    end

    always @(negedge clk) begin
        int idx;
        idx = int'(bus.cache_addr[3:0]);
        case (bus.cache_cntrl)
            CMD_CLR: for (int i = 0; i < 16; i++) begin c_vld[i] = 1'b0; c_dty[i] = 1'b0; end
            CMD_CHECK: begin
                bus.cache_hit     = c_vld[idx] && (c_tag[idx] == bus.cache_addr[7:4]);
                bus.cache_clean   = !c_dty[idx];
                bus.cache_wb_data = c_dat[idx];
                bus.cache_wb_addr = {c_tag[idx], bus.cache_addr[3:0]};
            end
            CMD_READ: bus.cache_dout = c_dat[idx];
            CMD_WRITE: begin
                c_tag[idx] = bus.cache_addr[7:4]; c_dat[idx] = bus.cache_din;
                c_vld[idx] = 1'b1; c_dty[idx] = 1'b1;
            end
            default: ;
        endcase
    end

    // RAM model: acks after ack_dly strobe cycles, one-cycle ack
    logic [7:0] ram_mem[256];
    int   ack_dly = 0;
    int   ram_cnt = 0;
    bit   spur_ack = 1'b0;
    int   we_low_cycles = 0;
    int   wr_count = 0;
    bit   unstable = 1'b0;
    bit   in_strobe = 1'b0;
    logic [7:0] hold_addr, hold_data;

    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = 8'h00;
        ram_mem[8'h23] = 8'h5A;
        ram_mem[8'h57] = 8'h77;
        ram_mem[8'h68] = 8'hC4;
        bus.ram_ack = 1'b0; bus.ram_rdata = '0;
    end

    always @(posedge clk) begin
        #1;
        bus.ram_ack = 1'b0;
        if (bus.ram_we || bus.ram_re) begin
            if (!in_strobe) begin
                in_strobe = 1'b1; hold_addr = bus.ram_addr; hold_data = bus.ram_wdata;
            end else if (bus.ram_addr !== hold_addr || (bus.ram_we && bus.ram_wdata !== hold_data)) begin
                unstable = 1'b1;
            end
            if (ram_cnt < ack_dly) begin
                ram_cnt++;
                if (bus.ram_we) we_low_cycles++;
            end else begin
                ram_cnt = 0; in_strobe = 1'b0; bus.ram_ack = 1'b1;
                if (ram_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL ram_unexpected: got we=%0b addr=%0h expected no RAM access", bus.ram_we, bus.ram_addr);
                end else begin
                    ram_txn_t e;
                    e = ram_q.pop_front();
                    chk("ram_we", int'(bus.ram_we), int'(e.we));
                    chk("ram_addr", int'(bus.ram_addr), int'(e.addr));
                    if (e.we) chk("ram_wdata", int'(bus.ram_wdata), int'(e.data));
                end
                if (bus.ram_we) begin
                    ram_mem[bus.ram_addr] = bus.ram_wdata; wr_count++;
                end else begin
                    bus.ram_rdata = ram_mem[bus.ram_addr];
                end
            end
        end else begin
            ram_cnt = 0; in_strobe = 1'b0;
            if (spur_ack) begin bus.ram_ack = 1'b1; spur_ack = 1'b0; end
        end
    end

    // CPU-side monitor
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.cache_cntrl == CMD_CLR) clr_seen++;
        if (bus.cache_cntrl == CMD_CHECK) t_acc = cyc;
        if (bus.cpu_ready) begin
            if (cpu_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL cpu_unexpected_ready: got ready=1 rdata=%0h expected no completion", bus.cpu_rdata);
            end else begin
                cpu_exp_t e;
                e = cpu_q.pop_front();
                chk({e.name, "_rdata"}, int'(bus.cpu_rdata), int'(e.rdata));
                chk({e.name, "_lat"}, cyc - t_acc, e.lat);
            end
        end
    end

    task automatic wait_ready(string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.cpu_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got no cpu_ready expected one within 200 cycles", name);
        end
    endtask

    task automatic do_req(string name, logic we, logic [7:0] addr, logic [7:0] wdata,
                          logic [7:0] exp_rdata, int lat, bit with_flush);
        @(posedge clk); #1;
        bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
        if (with_flush) bus.cpu_flush = 1'b1;
        cpu_q.push_back(cpu_exp_t'{rdata: exp_rdata, lat: lat, name: name});
        if (with_flush) begin
            @(posedge clk); #1 bus.cpu_flush = 1'b0;
            @(negedge clk);
            chk({name, "_clr_first"}, int'(bus.cache_cntrl), int'(CMD_CLR));
            exp_clr++;
        end
        wait_ready(name);
        bus.cpu_req = 1'b0;
    endtask

    task automatic do_flush();
        @(posedge clk); #1 bus.cpu_flush = 1'b1;
        @(posedge clk); #1 bus.cpu_flush = 1'b0;
        @(negedge clk);
        chk("flush_clr", int'(bus.cache_cntrl), int'(CMD_CLR));
        exp_clr++;
        @(negedge clk);
        chk("flush_back_read", int'(bus.cache_cntrl), int'(CMD_READ));
    endtask

    function automatic ram_txn_t txn(logic we, logic [7:0] addr, logic [7:0] data);
        return ram_txn_t'{we: we, addr: addr, data: data};
    endfunction

    initial begin
        int wr_base;
        bit seen;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_flush = 1'b0;
        bus.cpu_addr = '0; bus.cpu_wdata = '0;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_cntrl", int'(bus.cache_cntrl), int'(CMD_READ));
        chk("rst_ready", int'(bus.cpu_ready), 0);
        chk("rst_rdata", int'(bus.cpu_rdata), 0);
        chk("rst_ram_we", int'(bus.ram_we), 0);
        chk("rst_ram_re", int'(bus.ram_re), 0);
        chk("rst_ram_addr", int'(bus.ram_addr), 0);
        chk("rst_cache_addr", int'(bus.cache_addr), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_req("ld_f3_hit", 1'b0, 8'hF3, 8'h00, 8'hFF, 2, 1'b0);

        ram_q.push_back(txn(1'b1, 8'hF3, 8'hFF));
        ram_q.push_back(txn(1'b0, 8'h23, 8'h00));
        do_req("ld_23_dirty_miss", 1'b0, 8'h23, 8'h00, 8'h5A, 4, 1'b0);
        do_req("ld_23_hit", 1'b0, 8'h23, 8'h00, 8'h5A, 2, 1'b0);

        do_flush();
        do_req("st_47_clean_miss", 1'b1, 8'h47, 8'h3C, 8'h5A, 2, 1'b0);
        do_req("ld_47_hit", 1'b0, 8'h47, 8'h00, 8'h3C, 2, 1'b0);

        ack_dly = 5; we_low_cycles = 0; wr_base = wr_count; unstable = 1'b0;
        ram_q.push_back(txn(1'b1, 8'h47, 8'h3C));
        do_req("st_57_dirty_wb", 1'b1, 8'h57, 8'h99, 8'h3C, 8, 1'b0);
        ack_dly = 0;
        chk("wb_hold_cycles", we_low_cycles, 5);
        chk("wb_single_write", wr_count - wr_base, 1);
        chk("wb_stable", int'(unstable), 0);

        ram_q.push_back(txn(1'b0, 8'h57, 8'h00));
        do_req("ld_57_with_flush", 1'b0, 8'h57, 8'h00, 8'h77, 3, 1'b1);

        // reset in the middle of a fill
        ack_dly = 20;
        @(posedge clk); #1;
        bus.cpu_we = 1'b0; bus.cpu_addr = 8'h68; bus.cpu_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ram_re) begin seen = 1'b1; break; end
        end
        chk("abort_fill_started", int'(seen), 1);
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        chk("abort_ram_re", int'(bus.ram_re), 0);
        chk("abort_ready", int'(bus.cpu_ready), 0);
        chk("abort_cntrl", int'(bus.cache_cntrl), int'(CMD_READ));
        bus.cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; ack_dly = 0;

        spur_ack = 1'b1;
        repeat (3) @(negedge clk);
        chk("spur_ack_we", int'(bus.ram_we), 0);
        chk("spur_ack_re", int'(bus.ram_re), 0);
        chk("spur_ack_cntrl", int'(bus.cache_cntrl), int'(CMD_READ));

        ram_q.push_back(txn(1'b0, 8'h68, 8'h00));
        do_req("ld_68_after_abort", 1'b0, 8'h68, 8'h00, 8'hC4, 3, 1'b0);
        ram_q.push_back(txn(1'b0, 8'hF3, 8'h00));
        do_req("ld_f3_refill", 1'b0, 8'hF3, 8'h00, 8'hFF, 3, 1'b0);
        do_req("st_68_hit", 1'b1, 8'h68, 8'h11, 8'hFF, 2, 1'b0);
        do_req("ld_68_hit", 1'b0, 8'h68, 8'h00, 8'h11, 2, 1'b0);

        repeat (4) @(negedge clk);
        chk("clr_count", clr_seen, exp_clr);
        chk("cpu_q_empty", cpu_q.size(), 0);
        chk("ram_q_empty", ram_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000ns");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
Initiator-side controller for the direct-mapped cache. It accepts single-word processor load/store requests, sequences the cache's 2-bit command port (CLR/CHECK/READ/WRITE), and performs dirty write-back and miss fill against RAM over a strobe/ack handshake. It sits between the processor datapath, the cache array and main RAM, and owns all cache commands.

Parameters:
RAM_WIDTH, 8, data word width, matching the cache line data field
ADDR_WIDTH, 8, byte/word address width
BLOCK_ADDR_BITS, 4, index bits; tag is ADDR_WIDTH-BLOCK_ADDR_BITS

Ports:
clk  in  1  system clock; controller registers update on posedge, the cache array acts on negedge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  request; level, held until cpu_ready
cpu_we  in  1  1=store, 0=load; sampled at acceptance
cpu_flush  in  1  invalidate-all request, single-cycle pulse
cpu_addr  in  ADDR_WIDTH  request address; sampled at acceptance
cpu_wdata  in  RAM_WIDTH  store data; sampled at acceptance
cpu_rdata  out  RAM_WIDTH  load data, valid while cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
cache_cntrl  out  2  00 CLR, 01 CHECK, 10 READ, 11 WRITE
cache_addr  out  ADDR_WIDTH  address to cache
cache_din  out  RAM_WIDTH  write data to cache
cache_dout  in  RAM_WIDTH  cache read data
cache_hit  in  1  tag match from CHECK
cache_clean  in  1  line not dirty, from CHECK
cache_wb_data  in  RAM_WIDTH  victim data from CHECK
cache_wb_addr  in  ADDR_WIDTH  victim address from CHECK
ram_addr  out  ADDR_WIDTH  RAM address
ram_wdata  out  RAM_WIDTH  RAM write data
ram_we  out  1  write strobe, held until ram_ack
ram_re  out  1  read strobe, held until ram_ack
ram_rdata  in  RAM_WIDTH  RAM read data, valid with ram_ack
ram_ack  in  1  RAM completion, one cycle

Behaviour:
- All outputs registered. Reset: state IDLE, cache_cntrl=10 (READ, harmless; 00 is never driven except in FLUSH), every other output 0.
- Each cache command is driven for exactly one cycle; its result is sampled on the next posedge.
- IDLE: cpu_flush -> FLUSH (flush wins over a simultaneous cpu_req; the req stays pending). Otherwise cpu_req -> latch addr/we/wdata, cache_cntrl=01, go to CHECK.
- FLUSH: cache_cntrl=00 for one cycle, then 10, back to IDLE. No cpu_ready.
- CHECK: hit & load -> cntrl=10, ACCESS. Hit & store -> cntrl=11, cache_din=wdata, ACCESS. Miss & !clean -> ram_we=1, ram_addr=cache_wb_addr, ram_wdata=cache_wb_data, WB. Miss & clean -> load: FILL; store: cntrl=11 with wdata, ACCESS.
- WB: hold the strobe until ram_ack (ack on the first cycle is legal). On ack drop ram_we, then load -> FILL, store -> cntrl=11 with wdata, ACCESS.
- FILL: ram_re=1, ram_addr=latched addr until ram_ack. On ack capture ram_rdata, cntrl=11 with cache_din=fill data, FILL_WR. The filled line becomes dirty; this is the cache's rule and is accepted.
- ACCESS / FILL_WR: next posedge -> cntrl=10, cpu_ready=1, cpu_rdata = cache_dout (load hit) or fill data (load miss), DONE.
- DONE: cpu_ready=0, IDLE. Next request is accepted no earlier than the following cycle.
- Latency from acceptance edge to cpu_ready high: hit 2 cycles; clean load miss 3+Tack; dirty miss adds the WB wait.
- cpu_rdata holds its value until the next load completes.
- Async reset mid-operation: immediate return to IDLE, RAM strobes drop, no cpu_ready. Cache contents are untouched. A partial RAM write is the RAM's concern.
- ram_ack outside WB/FILL is ignored.

Decomposition:
- Shared package: cache command constants (CMD_CLR/CHECK/READ/WRITE) and the state encoding. The package must also be usable by the cache array.
- Single module; no sub-module needed.

Test Plan:
- Reset, load 0xF3 (cache powers up all-ones: tag F, dirty) -> hit, no RAM activity, cpu_rdata=0xFF, ready 2 cycles after acceptance.
- Load 0x23 after reset -> WB with ram_addr=0xF3, ram_wdata=0xFF; then FILL at 0x23 with RAM returning 0x5A -> cpu_rdata=0x5A. Reload 0x23 -> hit 0x5A.
- Flush, then store 0x47 <- 0x3C -> clean miss, no RAM traffic, WRITE issued. Load 0x47 -> hit 0x3C. Store 0x57 -> WB with addr=0x47, data=0x3C.
- cpu_flush and cpu_req in the same cycle -> CLR first, then the request is serviced. cache_cntrl=00 appears only then.
- Hold ram_ack low 5 cycles during WB -> ram_we held stable 5 cycles, single write.
- Assert rst_n low during FILL -> ram_re drops immediately, no cpu_ready, next request is serviced normally.
